pim_buf_streamer: RTL and testbench

Read-side initiator for the PIM buffer SRAM port. On a start command it issues a burst of word reads from a base address and converts the fixed one-cycle SRAM read latency into a valid/ready output stream. A small credit-tracked FIFO absorbs backpressure, and the PIM datapath consumes the stream. The block never writes the buffer.

---
 rtl/pim_buf_pkg.sv | 24 ++
 rtl/pim_stream_fifo.sv | 63 ++++++
 rtl/pim_buf_streamer.sv | 166 ++++++++++++++++
 tb/tb_pim_buf_streamer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_buf_pkg.sv
// Shared definitions for the PIM buffer read streamer: controller states,
// buffer word geometry and the tie-off value for the byte-lane write enables.
package pim_buf_pkg;

   // Burst controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } stream_state_t;

   // One buffer word is 32 bits wide, so consecutive words are 4 bytes apart
   localparam int PIM_WORD_BYTES = 4;

   // Byte-lane write enables are active-low; all ones keeps every lane disabled
   localparam logic [3:0] PIM_BUF_NO_WRITE_MASK = 4'b1111;

   // Clears the byte-offset bits so a byte address points at the start of its word
   function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pim_stream_fifo.sv
// Small synchronous FIFO used as the output stage of the buffer streamer.
// Writes become visible at the head one cycle later (no combinational bypass).
// A push and a pop in the same cycle are both honoured, even when the FIFO is
// full (the freed slot is refilled) or empty (the pop is simply ignored).
module pim_stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a reset flushes everything stored
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/pim_buf_streamer.sv
// Read-side initiator for the PIM buffer SRAM port. A start command launches a
// burst of word reads from a base address; the fixed one-cycle SRAM latency is
// turned into a valid/ready stream through a credit-tracked output FIFO.
// The buffer is never written.
//
// Optional build macro: PIM_BUF_STREAMER_STRIDE_EN adds i_stride, a word
// stride latched at start (address step = i_stride*4, wrapping in the decoded
// address space). Without it the step is one word.
module pim_buf_streamer
   import pim_buf_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 15,
   parameter int LEN_WIDTH      = 16,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic [31:0]                 i_base_addr,
   input  logic [LEN_WIDTH-1:0]        i_len,
`ifdef PIM_BUF_STREAMER_STRIDE_EN
   input  logic [MEM_ADDR_WIDTH-3:0]   i_stride,
`endif
   output logic                        o_busy,
   output logic                        o_done,
   output logic [31:0]                 o_buf_addr,
   input  logic [31:0]                 i_buf_rd_data,
   output logic [31:0]                 o_buf_wr_data,
   output logic [3:0]                  o_buf_size,
   output logic                        o_buf_write,
   output logic                        o_buf_read,
   output logic [31:0]                 o_data,
   output logic                        o_valid,
   input  logic                        i_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   stream_state_t              state;
   stream_state_t              state_next;

   logic [MEM_ADDR_WIDTH-1:0]  addr_q;
   logic [MEM_ADDR_WIDTH-1:0]  addr_step;
   logic [LEN_WIDTH-1:0]       remaining;
   logic                       inflight;
   logic                       issue;
   logic                       pop;
   logic                       accept;

   logic [31:0]                fifo_rd_data;
   logic                       fifo_empty;
   logic                       unused_fifo_full;
   logic [CW-1:0]              fifo_count;

   logic [CW:0]                credits_used;
   logic [CW:0]                credits_limit;

`ifdef PIM_BUF_STREAMER_STRIDE_EN
   logic [MEM_ADDR_WIDTH-3:0]  stride_q;

   assign addr_step = {stride_q, 2'b00};
`else
   assign addr_step = MEM_ADDR_WIDTH'(PIM_WORD_BYTES);
`endif

   // A start only counts while idle; later pulses are ignored
   assign accept = (state == IDLE) && i_start;

   // The stream consumes the FIFO head whenever the consumer is ready
   assign pop = !fifo_empty && i_ready;

   // Credit check: words stored plus the word in flight, less the word leaving
   // this cycle, must leave a free slot so the capture next cycle always fits
   assign credits_used  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign credits_limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
   assign issue         = (state == RUN) && (credits_used < credits_limit);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; DRAIN anticipates the final pop so o_done follows the
   // last transfer by exactly one cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next = (i_len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (issue && (remaining == LEN_WIDTH'(1))) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight && (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Address generator, word counter and the one-deep in-flight tag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         addr_q    <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
`ifdef PIM_BUF_STREAMER_STRIDE_EN
         stride_q  <= '0;
`endif
      end else begin
         inflight <= issue;
         if (accept) begin
            addr_q    <= MEM_ADDR_WIDTH'(word_align(i_base_addr));
            remaining <= i_len;
`ifdef PIM_BUF_STREAMER_STRIDE_EN
            stride_q  <= i_stride;
`endif
         end else if (issue) begin
            addr_q    <= addr_q + addr_step;
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

   // Read data arriving for the previous issue is captured unconditionally
   pim_stream_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_clk),
      .rst     (i_rst),
      .push    (inflight),
      .pop     (pop),
      .wr_data (i_buf_rd_data),
      .rd_data (fifo_rd_data),
      .full    (unused_fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign o_busy        = (state == RUN) || (state == DRAIN);
   assign o_done        = (state == DONE);
   assign o_buf_addr    = {{(32-MEM_ADDR_WIDTH){1'b0}}, addr_q};
   assign o_buf_wr_data = 32'h0;
   assign o_buf_size    = PIM_BUF_NO_WRITE_MASK;
   assign o_buf_write   = 1'b0;
   assign o_buf_read    = 1'b1;
   assign o_valid       = !fifo_empty;
   assign o_data        = fifo_empty ? 32'h0 : fifo_rd_data;

endmodule

// File: tb/tb_pim_buf_streamer.sv
// Self-checking bench for pim_buf_streamer. A behavioural model turns every
// accepted start into the list of words the stream must deliver and predicts
// o_done/o_busy from the handshake count; directed bursts add literal checks.
// Honours PIM_BUF_STREAMER_STRIDE_EN when the design is built with it.
`timescale 1ns/1ps
module tb_pim_buf_streamer;

   localparam int MAW   = 15;
   localparam int LW    = 16;
   localparam int DEPTH = 2;
   localparam logic [31:0] ADDR_MASK = (32'h1 << MAW) - 32'h1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   base;
   logic [LW-1:0] len;
   logic          ready;
   logic [31:0]   rd_data;
   logic [31:0]   salt;
`ifdef PIM_BUF_STREAMER_STRIDE_EN
   logic [MAW-3:0] stride;
`endif

   logic          busy;
   logic          done;
   logic [31:0]   buf_addr;
   logic [31:0]   buf_wr_data;
   logic [3:0]    buf_size;
   logic          buf_write;
   logic          buf_read;
   logic [31:0]   data;
   logic          valid;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q [$];
   int          words_left = 0;
   bit          m_active   = 1'b0;
   bit          m_done_now = 1'b0;
   bit          prev_stall = 1'b0;
   bit          was_active;
   bit          next_done;
   logic [31:0] prev_data  = 32'h0;
   bit          monitor_on = 1'b0;
   int          xfer_count = 0;

   pim_buf_streamer #(
      .MEM_ADDR_WIDTH (MAW),
      .LEN_WIDTH      (LW),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_base_addr   (base),
      .i_len         (len),
`ifdef PIM_BUF_STREAMER_STRIDE_EN
      .i_stride      (stride),
`endif
      .o_busy        (busy),
      .o_done        (done),
      .o_buf_addr    (buf_addr),
      .i_buf_rd_data (rd_data),
      .o_buf_wr_data (buf_wr_data),
      .o_buf_size    (buf_size),
      .o_buf_write   (buf_write),
      .o_buf_read    (buf_read),
      .o_data        (data),
      .o_valid       (valid),
      .i_ready       (ready)
   );

   always #5 clk = ~clk;

   // Buffer model: data for an address appears one cycle after it is presented
   always @(posedge clk) begin
      rd_data <= buf_addr ^ salt;
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
      end
   endtask

   function automatic logic [31:0] model_step();
`ifdef PIM_BUF_STREAMER_STRIDE_EN
      return 32'({stride, 2'b00});
`else
      return 32'd4;
`endif
   endfunction

   // Expected word list for a burst: aligned base, fixed step, wrapping address space
   function automatic void load_burst(input logic [31:0] b, input int n,
                                      input logic [31:0] step, input logic [31:0] s);
      logic [31:0] a;
      exp_q.delete();
      a = b & ADDR_MASK & 32'hFFFF_FFFC;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(a ^ s);
         a = (a + step) & ADDR_MASK;
      end
   endfunction

   // Per-cycle compare against the model, then advance the model one cycle
   always @(negedge clk) begin
      if (monitor_on) begin
         check_output("o_done", 32'(done), 32'(m_done_now));
         check_output("o_busy", 32'(busy), 32'(m_active));
         if (!m_active) begin
            check_output("o_valid_idle", 32'(valid), 32'd0);
         end
         if (prev_stall) begin
            check_output("hold_valid", 32'(valid), 32'd1);
            check_output("hold_data", data, prev_data);
         end
         if (valid && ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
               check_output("extra_word", 32'(valid), 32'd0);
            end else begin
               check_output("o_data", data, exp_q.pop_front());
            end
         end
         next_done  = 1'b0;
         was_active = m_active;
         if (rst) begin
            exp_q.delete();
            words_left = 0;
            m_active   = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (valid && ready && was_active) begin
               words_left--;
               if (words_left == 0) begin
                  m_active  = 1'b0;
                  next_done = 1'b1;
               end
            end
            if (start && !was_active && !m_done_now) begin
               if (len == '0) begin
                  next_done = 1'b1;
               end else begin
                  load_burst(base, int'(len), model_step(), salt);
                  words_left = int'(len);
                  m_active   = 1'b1;
               end
            end
            prev_stall = valid && !ready;
            prev_data  = data;
         end
         m_done_now = next_done;
      end
   end

   function automatic logic pick_ready(input int mode, input int k);
      case (mode)
         1:       return (k % 3) == 0;
         2:       return $urandom_range(0, 3) != 0;
         default: return 1'b1;
      endcase
   endfunction

   // Runs one burst to completion; mode 2 adds stray starts, mode 3 one mid-burst start
   task automatic apply_stimulus(input logic [31:0] b, input int n, input int mode,
                                 input int budget);
      int k;
      base  = b;
      len   = LW'(n);
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base  = $urandom;
      len   = LW'($urandom);
      k = 1;
      while ((m_active || m_done_now) && k < budget) begin
         ready = pick_ready(mode, k);
         start = ((mode == 2) && ($urandom_range(0, 15) == 0)) || ((mode == 3) && (k == 2));
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      ready = 1'b1;
      if (m_active || m_done_now) begin
         check_output("burst_timeout", 32'd1, 32'd0);
      end
   endtask

   // Directed burst with ready held high: addresses, data and timing as literals
   task automatic directed_burst(input string tag, input logic [31:0] b,
                                 input logic [31:0] exp_addr [4]);
      base  = b;
      len   = LW'(4);
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c <= 4) begin
            check_output($sformatf("%s_addr_c%0d", tag, c), buf_addr, exp_addr[c-1]);
         end
         check_output($sformatf("%s_valid_c%0d", tag, c), 32'(valid),
                      (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
         if (c >= 3 && c <= 6) begin
            check_output($sformatf("%s_data_c%0d", tag, c), data, exp_addr[c-3]);
         end
         check_output($sformatf("%s_done_c%0d", tag, c), 32'(done), (c == 7) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [31:0] t_addr [4];
      int          n0;
      rst   = 1'b1;
      start = 1'b0;
      base  = 32'h0;
      len   = '0;
      ready = 1'b1;
      salt  = 32'h0;
`ifdef PIM_BUF_STREAMER_STRIDE_EN
      stride = 1;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst        = 1'b0;
      monitor_on = 1'b1;

      @(negedge clk);
      check_output("rst_valid", 32'(valid), 32'd0);
      check_output("rst_data", data, 32'h0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_buf_addr", buf_addr, 32'h0);
      check_output("tie_wr_data", buf_wr_data, 32'h0);
      check_output("tie_size", 32'(buf_size), 32'hF);
      check_output("tie_write", 32'(buf_write), 32'd0);
      check_output("tie_read", 32'(buf_read), 32'd1);
      @(posedge clk); #1;

      t_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
      directed_burst("seq", 32'h100, t_addr);

      t_addr = '{32'h7FF8, 32'h7FFC, 32'h0000, 32'h0004};
      directed_burst("wrap", 32'h7FF8, t_addr);

      base  = 32'h200;
      len   = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_output("zero_done_c1", 32'(done), 32'd1);
      check_output("zero_busy_c1", 32'(busy), 32'd0);
      check_output("zero_valid_c1", 32'(valid), 32'd0);
      @(negedge clk);
      check_output("zero_done_c2", 32'(done), 32'd0);
      check_output("zero_busy_c2", 32'(busy), 32'd0);
      @(posedge clk); #1;

      apply_stimulus(32'h100, 8, 1, 200);

      salt  = 32'hC0DE_0000;
      n0    = xfer_count;
      base  = 32'h2000;
      len   = LW'(10);
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && xfer_count < n0 + 3; k++) begin
         @(posedge clk); #1;
      end
      check_output("abort_reached_3", 32'(xfer_count >= n0 + 3), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("abort_valid", 32'(valid), 32'd0);
      check_output("abort_data", data, 32'h0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      apply_stimulus(32'h300, 5, 3, 200);

`ifdef PIM_BUF_STREAMER_STRIDE_EN
      salt   = 32'h0;
      stride = 3;
      base   = 32'h40;
      len    = LW'(3);
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t_addr = '{32'h40, 32'h4C, 32'h58, 32'h0};
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check_output($sformatf("stride_addr_c%0d", c), buf_addr, t_addr[c-1]);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 50 && (m_active || m_done_now); k++) begin
         @(posedge clk); #1;
      end
      stride = 1;
`endif

      for (int i = 0; i < 25; i++) begin
         salt = $urandom;
`ifdef PIM_BUF_STREAMER_STRIDE_EN
         stride = MAW'($urandom_range(0, 9)) ;
`endif
         apply_stimulus($urandom, $urandom_range(0, 12), $urandom_range(0, 2), 400);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
